// File: rtl/pipe_if_id_skid.sv
// IF/ID pipeline register with valid/ready handshake and a one-entry skid buffer.
// The main register drives decode; the skid register catches the single beat that
// fetch can launch in the cycle decode starts stalling, so up_ready_o depends only
// on registered state. Flush inserts a NOP bubble. Saturating counters track stall
// and flush events.
module pipe_if_id_skid #(
   parameter int                 PC_W    = 32,
   parameter int                 INSTR_W = 32,
   parameter logic [INSTR_W-1:0] NOP     = 32'h00000013,
   parameter int                 CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               stall_i,
   input  logic               up_valid_i,
   output logic               up_ready_o,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instruction_i,
   output logic               dn_valid_o,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instruction_o,
   output logic [CNT_W-1:0]   stall_cnt_o,
   output logic [CNT_W-1:0]   flush_cnt_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t             state_p1;
   logic               vld_p1;
   logic               rdy_p1;
   logic [PC_W-1:0]    pc_p1;
   logic [INSTR_W-1:0] instr_p1;
   logic [PC_W-1:0]    skid_pc_p1;
   logic [INSTR_W-1:0] skid_instr_p1;
   logic [CNT_W-1:0]   stall_cnt_p1;
   logic [CNT_W-1:0]   flush_cnt_p1;
   logic               accept;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign accept        = up_valid_i && rdy_p1;
   assign up_ready_o    = rdy_p1;
   assign dn_valid_o    = vld_p1;
   assign pc_o          = pc_p1;
   assign instruction_o = instr_p1;
   assign stall_cnt_o   = stall_cnt_p1;
   assign flush_cnt_o   = flush_cnt_p1;

   // Handshake FSM, main/skid storage and performance counters; reset beats flush beats stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_p1      <= EMPTY;
         vld_p1        <= 1'b0;
         rdy_p1        <= 1'b1;
         pc_p1         <= '0;
         instr_p1      <= NOP;
         skid_pc_p1    <= '0;
         skid_instr_p1 <= NOP;
         stall_cnt_p1  <= '0;
         flush_cnt_p1  <= '0;
      end else begin
         if (stall_i && vld_p1 && !flush_i)
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
         // Only flushes that actually throw away a real beat are counted.
         if (flush_i && (vld_p1 || (state_p1 == FULL) || accept))
            flush_cnt_p1 <= sat_inc(flush_cnt_p1);

         if (flush_i) begin
            state_p1 <= EMPTY;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
            instr_p1 <= NOP;
         end else begin
            case (state_p1)
               EMPTY: begin
                  if (accept) begin
                     pc_p1    <= pc_i;
                     instr_p1 <= instruction_i;
                     vld_p1   <= 1'b1;
                     state_p1 <= ONE;
                  end
               end
               ONE: begin
                  if (!stall_i) begin
                     if (accept) begin
                        pc_p1    <= pc_i;
                        instr_p1 <= instruction_i;
                     end else begin
                        vld_p1   <= 1'b0;
                        instr_p1 <= NOP;
                        state_p1 <= EMPTY;
                     end
                  end else if (accept) begin
                     // Decode stalled while fetch had a beat in flight: park it.
                     skid_pc_p1    <= pc_i;
                     skid_instr_p1 <= instruction_i;
                     rdy_p1        <= 1'b0;
                     state_p1      <= FULL;
                  end
               end
               FULL: begin
                  if (!stall_i) begin
                     pc_p1    <= skid_pc_p1;
                     instr_p1 <= skid_instr_p1;
                     rdy_p1   <= 1'b1;
                     state_p1 <= ONE;
                  end
               end
               default: begin
                  state_p1 <= EMPTY;
                  vld_p1   <= 1'b0;
                  rdy_p1   <= 1'b1;
                  instr_p1 <= NOP;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_if_id_skid.sv
// Bench for pipe_if_id_skid: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based model of the buffer.
module tb_pipe_if_id_skid;

   localparam int          CNT_W = 4;
   localparam logic [31:0] NOPI  = 32'h00000013;

   logic             clk = 1'b0;
   logic             rst, flush, stall, up_valid;
   logic             up_ready, dn_valid;
   logic [31:0]      pc_in, instr_in, pc_out, instr_out;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } beat_t;

   beat_t            mq[$];
   logic [31:0]      m_pc;
   logic [CNT_W-1:0] m_stall_cnt, m_flush_cnt;

   pipe_if_id_skid #(
      .PC_W(32), .INSTR_W(32), .NOP(NOPI), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
      .up_valid_i(up_valid), .up_ready_o(up_ready),
      .pc_i(pc_in), .instruction_i(instr_in),
      .dn_valid_o(dn_valid), .pc_o(pc_out), .instruction_o(instr_out),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: a FIFO of at most two held beats; the head is what decode sees.
   task automatic model_step(input logic r, f, s, v, input logic [31:0] p, ins);
      logic acc, dv;
      beat_t b;
      if (r) begin
         mq.delete();
         m_pc = 32'h0;
         m_stall_cnt = '0;
         m_flush_cnt = '0;
         return;
      end
      acc = v && (mq.size() < 2);
      dv  = (mq.size() > 0);
      if (s && dv && !f && m_stall_cnt != {CNT_W{1'b1}}) m_stall_cnt = m_stall_cnt + 1'b1;
      if (f && (dv || acc) && m_flush_cnt != {CNT_W{1'b1}}) m_flush_cnt = m_flush_cnt + 1'b1;
      if (f) begin
         mq.delete();
      end else begin
         if (dv && !s) void'(mq.pop_front());
         if (acc) begin
            b.pc = p;
            b.ins = ins;
            mq.push_back(b);
         end
      end
      if (mq.size() > 0) m_pc = mq[0].pc;
   endtask

   task automatic check_outputs();
      check("dn_valid", {31'b0, dn_valid}, {31'b0, mq.size() > 0});
      check("up_ready", {31'b0, up_ready}, {31'b0, mq.size() < 2});
      check("instr", instr_out, (mq.size() > 0) ? mq[0].ins : NOPI);
      check("pc", pc_out, m_pc);
      check("stall_cnt", {28'b0, stall_cnt}, {28'b0, m_stall_cnt});
      check("flush_cnt", {28'b0, flush_cnt}, {28'b0, m_flush_cnt});
   endtask

   task automatic step(input logic r, f, s, v, input logic [31:0] p, ins);
      rst = r; flush = f; stall = s; up_valid = v; pc_in = p; instr_in = ins;
      model_step(r, f, s, v, p, ins);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      logic f, s, v;
      rst = 1'b1; flush = 1'b0; stall = 1'b0; up_valid = 1'b0;
      pc_in = '0; instr_in = '0;

      // 1: reset then three back-to-back beats
      step(1, 0, 0, 0, 32'h0, 32'h0);
      check("rst_dn_valid", {31'b0, dn_valid}, 32'h0);
      check("rst_instr", instr_out, NOPI);
      check("rst_pc", pc_out, 32'h0);
      check("rst_ready", {31'b0, up_ready}, 32'h1);
      step(0, 0, 0, 1, 32'h0, 32'hA);
      check("t1_instrA", instr_out, 32'hA);
      step(0, 0, 0, 1, 32'h4, 32'hB);
      check("t1_instrB", instr_out, 32'hB);
      step(0, 0, 0, 1, 32'h8, 32'hC);
      check("t1_pcC", pc_out, 32'h8);
      step(0, 0, 0, 0, 32'h0, 32'h0);
      check("t1_drain", {31'b0, dn_valid}, 32'h0);

      // 2: stall with a beat in flight fills the skid, release drains in order
      step(1, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 1, 32'h4, 32'hB);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 32'h8, 32'hC);
         check("t2_held", instr_out, 32'hB);
      end
      check("t2_full_ready", {31'b0, up_ready}, 32'h0);
      check("t2_stall_cnt", {28'b0, stall_cnt}, 32'h3);
      step(0, 0, 0, 1, 32'hC, 32'hD);
      check("t2_skid_out", instr_out, 32'hC);
      step(0, 0, 0, 1, 32'hC, 32'hD);
      check("t2_next", pc_out, 32'hC);
      check("t2_nextD", instr_out, 32'hD);

      // 3: flush beats stall in FULL; flush while empty is not counted
      step(1, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 1, 32'h0, 32'hA);
      step(0, 0, 1, 1, 32'h4, 32'hB);
      step(0, 1, 1, 1, 32'h8, 32'hC);
      check("t3_nop", instr_out, NOPI);
      check("t3_ready", {31'b0, up_ready}, 32'h1);
      check("t3_flush_cnt", {28'b0, flush_cnt}, 32'h1);
      step(0, 1, 0, 0, 32'h8, 32'hC);
      check("t3_flush_empty", {28'b0, flush_cnt}, 32'h1);

      // 4: reset in FULL while stalled; skid beat must never appear
      step(0, 0, 0, 1, 32'h10, 32'hE);
      step(0, 0, 1, 1, 32'h14, 32'hF);
      step(1, 0, 1, 1, 32'h18, 32'h11);
      check("t4_rst_instr", instr_out, NOPI);
      check("t4_rst_cnt", {28'b0, flush_cnt}, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 0, 0, 32'h0, 32'h0);
      check("t4_no_stale", {31'b0, dn_valid}, 32'h0);

      // 5: long stall saturates the counter
      step(0, 0, 0, 1, 32'h20, 32'h21);
      for (int i = 0; i < (1 << CNT_W) + 5; i++) step(0, 0, 1, 0, 32'h0, 32'h0);
      check("t5_sat", {28'b0, stall_cnt}, 32'hF);
      step(1, 0, 0, 0, 32'h0, 32'h0);

      // 6: random traffic
      for (int i = 0; i < 10000; i++) begin
         f = ($urandom_range(0, 19) == 0);
         s = ($urandom_range(0, 2) == 0);
         v = ($urandom_range(0, 3) != 0);
         step(0, f, s, v, 32'(i) * 4, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
